// File: rtl/axis_pkt_len_counter_pkg.sv
// Shared definitions for the packet-length monitor: length-word flag positions
// and the tkeep decode helpers (byte count and contiguity legality).
package axis_len_pkg;

  localparam int LEN_FLAG_BAD_TKEEP = 0;
  localparam int LEN_FLAG_OVERFLOW  = 1;
  localparam int LEN_FLAGS_W        = 2;

  // Helpers take tkeep zero-extended to this width so one function serves every DATA_W.
  localparam int KEEP_MAX_W = 128;
  localparam int KEEP_IDX_W = $clog2(KEEP_MAX_W);

  function automatic int keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (keep[i]) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  // Walk from the aligned end: once a clear byte is seen, any later set byte is illegal.
  function automatic logic keep_contiguous(input logic [KEEP_MAX_W-1:0] keep,
                                           input int                    keep_w,
                                           input logic                  align_msb);
    logic seen_gap;
    logic ok;
    int   idx;
    seen_gap = 1'b0;
    ok       = 1'b1;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (i < keep_w) begin
        idx = align_msb ? (keep_w - 1 - i) : i;
        if (keep[idx[KEEP_IDX_W-1:0]]) begin
          if (seen_gap) begin
            ok = 1'b0;
          end else begin
            ok = ok;
          end
        end else begin
          seen_gap = 1'b1;
        end
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/axis_pkt_len_counter_if.sv
// Stream and length side-channel interfaces used by the packet-length monitor.
interface axis_stream_if #(
  parameter int DATA_W = 64
) ();
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface len_stream_if
  import axis_len_pkg::*;
#(
  parameter int LEN_W = 16
) ();
  logic [LEN_W-1:0]       tdata;
  logic [LEN_FLAGS_W-1:0] tuser;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tuser, tvalid, input tready);
  modport slave  (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_len_counter_keep_decode.sv
// Combinational tkeep decode: byte count of one beat and whether its enables
// form a single run from the aligned end.
module axis_keep_decode
  import axis_len_pkg::*;
#(
  parameter int KEEP_W    = 8,
  parameter bit ALIGN_MSB = 1'b1,
  parameter int N_W       = $clog2(KEEP_W) + 1
) (
  input  logic [KEEP_W-1:0] keep_i,
  output logic [N_W-1:0]    n_o,
  output logic              legal_o
);

  logic [KEEP_MAX_W-1:0] keep_ext_s;

  // Widen tkeep and evaluate the shared helpers.
  always_comb begin
    keep_ext_s             = '0;
    keep_ext_s[KEEP_W-1:0] = keep_i;
    n_o                    = N_W'(keep_popcount(keep_ext_s));
    legal_o                = keep_contiguous(keep_ext_s, KEEP_W, ALIGN_MSB);
  end

endmodule

// File: rtl/axis_pkt_len_counter.sv
// Inline AXI-Stream monitor: passes the stream through and emits one saturating
// byte-count word (with bad-tkeep/overflow flags) per packet on a side channel.
module axis_pkt_len_counter
  import axis_len_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 16,
  parameter bit ALIGN_MSB = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  axis_stream_if.slave  s_axis,
  axis_stream_if.master m_axis,
  len_stream_if.master  len
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int N_W    = $clog2(KEEP_W) + 1;
  localparam int SUM_W  = (LEN_W > N_W) ? (LEN_W + 1) : (N_W + 1);

  logic [LEN_W-1:0]       acc_q, acc_d;
  logic [LEN_FLAGS_W-1:0] flags_q, flags_d;
  logic [LEN_W-1:0]       len_data_q, len_data_d;
  logic [LEN_FLAGS_W-1:0] len_user_q, len_user_d;
  logic                   len_valid_q, len_valid_d;

  logic                   slot_ok_s;
  logic                   fire_s;
  logic [N_W-1:0]         beat_n_s;
  logic                   beat_legal_s;
  logic [SUM_W-1:0]       sum_s;
  logic                   ovf_s;
  logic [LEN_W-1:0]       sat_s;
  logic [LEN_FLAGS_W-1:0] beat_flags_s;

  axis_keep_decode #(
    .KEEP_W    (KEEP_W),
    .ALIGN_MSB (ALIGN_MSB),
    .N_W       (N_W)
  ) u_keep_decode (
    .keep_i  (s_axis.tkeep),
    .n_o     (beat_n_s),
    .legal_o (beat_legal_s)
  );

  // A last beat may only proceed when the length slot is free or draining now.
  assign slot_ok_s     = ~s_axis.tlast | ~len_valid_q | len.tready;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = s_axis.tvalid & slot_ok_s;
  assign s_axis.tready = m_axis.tready & slot_ok_s;
  assign fire_s        = s_axis.tvalid & s_axis.tready;

  assign len.tdata  = len_data_q;
  assign len.tuser  = len_user_q;
  assign len.tvalid = len_valid_q;

  // Saturating accumulate and per-beat flags.
  always_comb begin
    sum_s                            = SUM_W'(acc_q) + SUM_W'(beat_n_s);
    ovf_s                            = |sum_s[SUM_W-1:LEN_W];
    sat_s                            = ovf_s ? {LEN_W{1'b1}} : sum_s[LEN_W-1:0];
    beat_flags_s                     = '0;
    beat_flags_s[LEN_FLAG_BAD_TKEEP] = ~beat_legal_s;
    beat_flags_s[LEN_FLAG_OVERFLOW]  = ovf_s;
  end

  // Next state for the accumulator and the length output slot.
  always_comb begin
    acc_d      = acc_q;
    flags_d    = flags_q;
    len_data_d = len_data_q;
    len_user_d = len_user_q;
    if (len_valid_q && len.tready) begin
      len_valid_d = 1'b0;
    end else begin
      len_valid_d = len_valid_q;
    end
    if (fire_s) begin
      if (s_axis.tlast) begin
        len_data_d  = sat_s;
        len_user_d  = flags_q | beat_flags_s;
        len_valid_d = 1'b1;
        acc_d       = '0;
        flags_d     = '0;
      end else begin
        acc_d   = sat_s;
        flags_d = flags_q | beat_flags_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      flags_q     <= '0;
      len_data_q  <= '0;
      len_user_q  <= '0;
      len_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      len_data_q  <= len_data_d;
      len_user_q  <= len_user_d;
      len_valid_q <= len_valid_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_len_counter.sv
// Bench for axis_pkt_len_counter: three configurations share one stimulus stream
// and are checked every cycle against a packet-level model plus literal values.
module tb_axis_pkt_len_counter;
  import axis_len_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_keep = 8'h00;
  logic        s_last = 1'b0;
  logic [63:0] s_data = 64'd0;
  logic        m_ready = 1'b1;
  logic        len_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_stream_if #(.DATA_W(64)) s0 ();
  axis_stream_if #(.DATA_W(64)) s1 ();
  axis_stream_if #(.DATA_W(64)) s2 ();
  axis_stream_if #(.DATA_W(64)) m0 ();
  axis_stream_if #(.DATA_W(64)) m1 ();
  axis_stream_if #(.DATA_W(64)) m2 ();
  len_stream_if  #(.LEN_W(16))  l0 ();
  len_stream_if  #(.LEN_W(16))  l1 ();
  len_stream_if  #(.LEN_W(4))   l2 ();

  assign s0.tdata = s_data;  assign s0.tkeep = s_keep;  assign s0.tlast = s_last;  assign s0.tvalid = s_valid;
  assign s1.tdata = s_data;  assign s1.tkeep = s_keep;  assign s1.tlast = s_last;  assign s1.tvalid = s_valid;
  assign s2.tdata = s_data;  assign s2.tkeep = s_keep;  assign s2.tlast = s_last;  assign s2.tvalid = s_valid;
  assign m0.tready = m_ready;  assign m1.tready = m_ready;  assign m2.tready = m_ready;
  assign l0.tready = len_ready; assign l1.tready = len_ready; assign l2.tready = len_ready;

  axis_pkt_len_counter #(.DATA_W(64), .LEN_W(16), .ALIGN_MSB(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0), .len(l0));
  axis_pkt_len_counter #(.DATA_W(64), .LEN_W(16), .ALIGN_MSB(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1), .len(l1));
  axis_pkt_len_counter #(.DATA_W(64), .LEN_W(4), .ALIGN_MSB(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_axis(s2), .m_axis(m2), .len(l2));

  logic        s_rdy [3];
  logic        m_vld [3];
  logic        l_vld [3];
  logic [31:0] l_data[3];
  logic [1:0]  l_user[3];
  logic        pass_ok[3];

  assign s_rdy[0] = s0.tready;  assign s_rdy[1] = s1.tready;  assign s_rdy[2] = s2.tready;
  assign m_vld[0] = m0.tvalid;  assign m_vld[1] = m1.tvalid;  assign m_vld[2] = m2.tvalid;
  assign l_vld[0] = l0.tvalid;  assign l_vld[1] = l1.tvalid;  assign l_vld[2] = l2.tvalid;
  assign l_data[0] = {16'd0, l0.tdata};
  assign l_data[1] = {16'd0, l1.tdata};
  assign l_data[2] = {28'd0, l2.tdata};
  assign l_user[0] = l0.tuser;  assign l_user[1] = l1.tuser;  assign l_user[2] = l2.tuser;
  assign pass_ok[0] = (m0.tdata == s_data) && (m0.tkeep == s_keep) && (m0.tlast == s_last);
  assign pass_ok[1] = (m1.tdata == s_data) && (m1.tkeep == s_keep) && (m1.tlast == s_last);
  assign pass_ok[2] = (m2.tdata == s_data) && (m2.tkeep == s_keep) && (m2.tlast == s_last);

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Packet-level model: legality means tkeep equals the aligned mask of its own popcount.
  function automatic bit keep_ok(input logic [7:0] k, input bit msb);
    int n;
    int m;
    n = $countones(k);
    m = (1 << n) - 1;
    if (msb) m = m << (8 - n);
    return k == m[7:0];
  endfunction

  bit   cfg_msb[3] = '{1'b1, 1'b0, 1'b1};
  int   cfg_max[3] = '{65535, 65535, 15};
  int   tot[3]     = '{0, 0, 0};
  bit   badf[3]    = '{1'b0, 1'b0, 1'b0};
  bit   pend       = 1'b0;
  int   e_len[3]   = '{0, 0, 0};
  logic [1:0] e_user[3] = '{2'b00, 2'b00, 2'b00};

  initial begin
    bit exp_slot;
    bit exp_srdy;
    bit exp_mvld;
    bit fire;
    forever begin
      @(negedge clk);
      exp_slot = !s_last || !pend || len_ready;
      exp_srdy = m_ready && exp_slot;
      exp_mvld = s_valid && exp_slot;
      for (int d = 0; d < 3; d++) begin
        check("s_tready", d, 32'(s_rdy[d]), 32'(exp_srdy));
        check("m_tvalid", d, 32'(m_vld[d]), 32'(exp_mvld));
        check("passthru", d, 32'(pass_ok[d]), 32'd1);
        check("len_tvalid", d, 32'(l_vld[d]), 32'(pend));
        check("len_tdata", d, l_data[d], 32'(e_len[d]));
        check("len_tuser", d, 32'(l_user[d]), 32'(e_user[d]));
      end
      if (!rst_n) begin
        pend = 1'b0;
        for (int d = 0; d < 3; d++) begin
          tot[d] = 0; badf[d] = 1'b0; e_len[d] = 0; e_user[d] = 2'b00;
        end
      end else begin
        fire = s_valid && exp_srdy;
        if (pend && len_ready) pend = 1'b0;
        if (fire) begin
          for (int d = 0; d < 3; d++) begin
            tot[d]  = tot[d] + $countones(s_keep);
            badf[d] = badf[d] | !keep_ok(s_keep, cfg_msb[d]);
            if (s_last) begin
              e_len[d]  = (tot[d] > cfg_max[d]) ? cfg_max[d] : tot[d];
              e_user[d] = {(tot[d] > cfg_max[d]), badf[d]};
              tot[d]    = 0;
              badf[d]   = 1'b0;
            end
          end
          if (s_last) pend = 1'b1;
        end
      end
    end
  end

  task automatic beat(input logic [7:0] k, input logic last, output int waits);
    s_valid = 1'b1; s_keep = k; s_last = last; s_data = {$urandom, $urandom};
    waits = 0;
    @(negedge clk);
    while (!s_rdy[0] && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!s_rdy[0]) begin
      total++; bad++;
      $display("FAIL beat_timeout actual=stalled required=accepted keep=%0h", k);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_keep = 8'h00; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    idle(3);
    rst_n = 1'b1;
    check("rst_vld", 0, 32'(l_vld[0]), 32'd0);
    check("rst_data", 0, l_data[0], 32'd0);
    check("rst_user", 0, 32'(l_user[0]), 32'd0);

    beat(8'hF0, 1'b1, w);
    check("t1_vld", 0, 32'(l_vld[0]), 32'd1);
    check("t1_len", 0, l_data[0], 32'd4);
    check("t1_user", 0, 32'(l_user[0]), 32'd0);
    idle(1);

    beat(8'hFF, 1'b0, w); check("t2_nostall", 0, 32'(w), 32'd0);
    beat(8'hFF, 1'b0, w); check("t2_nostall", 0, 32'(w), 32'd0);
    beat(8'hFE, 1'b1, w); check("t2_nostall", 0, 32'(w), 32'd0);
    check("t2_len", 0, l_data[0], 32'd23);
    check("t2_user", 0, 32'(l_user[0]), 32'd0);
    check("t2_user", 1, 32'(l_user[1]), 32'd1);
    check("t2_len", 2, l_data[2], 32'd15);
    check("t2_user", 2, 32'(l_user[2]), 32'd2);
    idle(1);

    len_ready = 1'b0;
    beat(8'hFF, 1'b1, w);
    check("t3_lenA", 0, l_data[0], 32'd8);
    s_valid = 1'b1; s_keep = 8'hC0; s_last = 1'b1; s_data = 64'h0123_4567_89AB_CDEF;
    repeat (3) begin
      @(negedge clk);
      check("t3_held_rdy", 0, 32'(s_rdy[0]), 32'd0);
      check("t3_held_vld", 0, 32'(m_vld[0]), 32'd0);
    end
    @(posedge clk); #1;
    len_ready = 1'b1;
    @(negedge clk);
    check("t3_release", 0, 32'(s_rdy[0]), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_keep = 8'h00;
    check("t3_lenB", 0, l_data[0], 32'd2);
    check("t3_vldB", 0, 32'(l_vld[0]), 32'd1);
    idle(1);

    beat(8'hA5, 1'b1, w);
    check("t4_len", 0, l_data[0], 32'd4);
    check("t4_user", 0, 32'(l_user[0]), 32'd1);
    idle(1);

    beat(8'h0F, 1'b1, w);
    check("t5_len", 1, l_data[1], 32'd4);
    check("t5_user", 1, 32'(l_user[1]), 32'd0);
    check("t5_user", 0, 32'(l_user[0]), 32'd1);
    beat(8'hF0, 1'b1, w);
    check("t5b_user", 1, 32'(l_user[1]), 32'd1);
    idle(1);

    beat(8'hFF, 1'b0, w);
    beat(8'hFF, 1'b0, w);
    beat(8'hFF, 1'b1, w);
    check("t6_len", 2, l_data[2], 32'd15);
    check("t6_user", 2, 32'(l_user[2]), 32'd2);
    check("t6_len", 0, l_data[0], 32'd24);
    idle(1);

    beat(8'hFF, 1'b0, w);
    beat(8'hFF, 1'b0, w);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t7_rst_data", 0, l_data[0], 32'd0);
    beat(8'hF0, 1'b1, w);
    check("t7_len", 0, l_data[0], 32'd4);
    check("t7_user", 0, 32'(l_user[0]), 32'd0);
    idle(1);

    beat(8'hFF, 1'b1, w);
    check("t8_len1", 0, l_data[0], 32'd8);
    check("t8_vld1", 0, 32'(l_vld[0]), 32'd1);
    beat(8'hF0, 1'b1, w);
    check("t8_len2", 0, l_data[0], 32'd4);
    check("t8_vld2", 0, 32'(l_vld[0]), 32'd1);
    idle(1);

    m_ready = 1'b0;
    s_valid = 1'b1; s_keep = 8'hFF; s_last = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t9_mstall_rdy", 0, 32'(s_rdy[0]), 32'd0);
      check("t9_mstall_vld", 0, 32'(m_vld[0]), 32'd1);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    beat(8'hFF, 1'b0, w);
    beat(8'h00, 1'b1, w);
    check("t9_len", 0, l_data[0], 32'd8);
    check("t9_user", 0, 32'(l_user[0]), 32'd0);
    check("t9_len", 2, l_data[2], 32'd8);
    idle(2);
    check("t10_hold_vld", 0, 32'(l_vld[0]), 32'd0);
    check("t10_hold_len", 0, l_data[0], 32'd8);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_pkt_len_counter.md
Name: axis_pkt_len_counter

Overview:
- Inline AXI-Stream monitor that passes data through unchanged.
- Accumulates the byte count of each packet from per-beat tkeep and emits one length word per packet on a separate valid/ready side channel.
- Generalises the codebase's combinational tkeep-to-length decode:
  - configurable data width, alignment mode and length width;
  - multi-beat accumulation, saturation, tkeep-legality flags and backpressure.
- Sits between a stream producer and consumer, e.g. ahead of header builders that need the packet length.

Parameters:
- DATA_W, 64, stream data width in bits; multiple of 8. KEEP_W = DATA_W/8.
- LEN_W, 16, width of the reported packet length in bytes.
- ALIGN_MSB, 1:
  - 1 = valid bytes are contiguous from tkeep[KEEP_W-1] downward;
  - 0 = contiguous from tkeep[0] upward.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tkeep  in  KEEP_W  input byte enables.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_W  = s_axis_tdata.
- m_axis_tkeep  out  KEEP_W  = s_axis_tkeep.
- m_axis_tlast  out  1  = s_axis_tlast.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- len_tdata  out  LEN_W  packet length in bytes.
- len_tuser  out  2  [0] bad_tkeep (sticky per packet), [1] overflow.
- len_tvalid  out  1  length word valid.
- len_tready  in  1  length word accepted.

Behaviour:
- Reset (rst_n=0 at clk edge): len_tvalid=0, len_tdata=0, len_tuser=0, accumulator=0, per-packet bad flag=0.
- Reset mid-packet discards the partial count; the next accepted beat starts a new packet.
- Pass-through: tdata/tkeep/tlast are combinational wires.
- slot_ok = !s_axis_tlast || !len_tvalid || len_tready.
- m_axis_tvalid = s_axis_tvalid && slot_ok. It never depends on m_axis_tready.
- s_axis_tready = m_axis_tready && slot_ok.
- fire = s_axis_tvalid && s_axis_tready.
- Beat length n = popcount(tkeep), range 0..KEEP_W.
- tkeep = 0 is a legal null beat with n = 0.
- Contiguity rule: legal iff the set bits form one run starting at the aligned end (MSB or LSB per ALIGN_MSB).
- Any other pattern sets that packet's bad flag; n is still the popcount.
- Saturating add: sum = acc + n computed at LEN_W+1 bits. If sum > 2^LEN_W-1, result = 2^LEN_W-1 and the overflow flag sets for that packet. Once saturated, stays saturated until packet end.
- fire && !tlast: acc <= sat(sum); flags accumulate.
- fire && tlast, on the next edge:
  - len_tdata <= sat(sum);
  - len_tuser <= accumulated flags OR this beat's flags;
  - len_tvalid <= 1;
  - acc <= 0 and flags <= 0.
- Latency: length word is valid one cycle after the last-beat handshake.
- len_tvalid && len_tready && no new load: len_tvalid <= 0. len_tdata and len_tuser hold their last value.
- Drain and load in the same cycle: len_tvalid stays 1 with the new data, giving one packet per cycle throughput.
- Backpressure: a last beat is held (s_tready=0, m_tvalid=0) only while an undrained length word is pending. Non-last beats are never stalled by the length channel.
- Length word ordering always matches packet order. Exactly one length word per packet.

Decomposition:
- Shared package (axis_len_pkg):
  - LEN_FLAG_BAD_TKEEP=0, LEN_FLAG_OVERFLOW=1;
  - popcount function;
  - contiguity-check function parameterised by alignment.
- One sub-module: axis_keep_decode, purely combinational.
  - Input: tkeep. Outputs: n ($clog2(KEEP_W)+1 bits) and legal.
  - Instantiated once.

Test Plan (DATA_W=64, LEN_W=16, ALIGN_MSB=1 unless noted):
- Single beat tkeep=8'hF0, tlast=1, len_tready=1 -> one cycle later len_tvalid=1, len_tdata=4, len_tuser=0; m_axis mirrors s_axis.
- Three beats tkeep 8'hFF, 8'hFF, 8'hFE (last) -> len_tdata=23, len_tuser=0; no stalls.
- Packet A = one beat 8'hFF; len_tready=0; packet B last beat 8'hC0 presented:
  - s_axis_tready=0 and m_axis_tvalid=0 while A is pending;
  - raise len_tready -> A (8) drains, B accepted, next cycle len_tdata=2.
- Single beat tkeep=8'hA5 -> len_tdata=4, len_tuser[0]=1.
- With ALIGN_MSB=0, tkeep=8'h0F -> len_tdata=4, flag 0; tkeep=8'hF0 -> flag 1.
- LEN_W=4, three beats 8'hFF -> len_tdata=15, len_tuser[1]=1.
- Two beats 8'hFF, rst_n=0 for one cycle, then single beat 8'hF0 last -> len_tdata=4, no flags.
- Back-to-back single-beat packets with len_tready=1 -> len_tvalid stays high; values 8, 4 on consecutive cycles.
